// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner slice.
// Only default parameter values live here; widths are derived where they are used.
package button_conditioner_pkg;
  localparam int DEF_NUM_BTN         = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 200000;
  localparam bit DEF_ACTIVE_LOW      = 1'b0;
endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins and the display counter.
// master drives the raw buttons; slave is the conditioner producing the cleaned outputs.
interface button_conditioner_if
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN
);
  logic [NUM_BTN-1:0] BTN_IN;
  logic [NUM_BTN-1:0] LEVEL;
  logic [NUM_BTN-1:0] PRESS;
  logic [NUM_BTN-1:0] RELEASE;
  logic [NUM_BTN-1:0] TOGGLE;

  modport master (
    output BTN_IN,
    input  LEVEL,
    input  PRESS,
    input  RELEASE,
    input  TOGGLE
  );

  modport slave (
    input  BTN_IN,
    output LEVEL,
    output PRESS,
    output RELEASE,
    output TOGGLE
  );
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: polarity fix, 2-FF synchronizer, stable-count debounce,
// registered press/release pulses and a press-toggled level.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic toggle
);
  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] count;
  logic             differs;
  logic             terminal;

  assign differs  = (sync2 != level);
  // Acceptance happens on the cycle the counter already sits at its last value.
  assign terminal = differs && (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      count         <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      sync1         <= btn_in ^ ACTIVE_LOW;
      sync2         <= sync1;
      press         <= terminal && sync2;
      release_pulse <= terminal && !sync2;
      if (!differs) begin
        count <= '0;
      end else if (terminal) begin
        count <= '0;
        level <= sync2;
      end else begin
        count <= count + 1'b1;
      end
      if (terminal && sync2) begin
        toggle <= !toggle;
      end
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw buttons for the display counter: TOGGLE feeds its
// direction control and PRESS feeds its count reset.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = DEF_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic                 CLK,
  input  logic                 RESET,
  button_conditioner_if.slave  bus
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk           (CLK),
      .rst           (RESET),
      .btn_in        (bus.BTN_IN[i]),
      .level         (bus.LEVEL[i]),
      .press         (bus.PRESS[i]),
      .release_pulse (bus.RELEASE[i]),
      .toggle        (bus.TOGGLE[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, NUM_BTN=2, ACTIVE_LOW=0.
// Expected PRESS/RELEASE events are queued when stimulus is applied and popped as pulses appear.
module tb_button_conditioner;
  localparam int NB = 2;
  localparam int DC = 4;
  localparam int KIND_PRESS   = 1;
  localparam int KIND_RELEASE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] exp_q[$];

  button_conditioner_if #(.NUM_BTN(NB)) bif();

  button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic [31:0] mk_ev(input int c, input int ch, input int kind);
    return 32'((c << 4) | (ch << 2) | kind);
  endfunction

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Every observed pulse must be the oldest outstanding expected event.
  always @(negedge clk) begin
    for (int ch = 0; ch < NB; ch++) begin
      if (bif.PRESS[ch] === 1'b1 || bif.RELEASE[ch] === 1'b1) begin
        logic [31:0] got;
        logic [31:0] want;
        got  = mk_ev(cyc, ch, int'({bif.RELEASE[ch], bif.PRESS[ch]}));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        check("event", got, want);
      end
    end
  end

  int t;
  logic [8:0] bounce_pat = 9'b111101101;  // bit 0 applied first

  initial begin
    bif.BTN_IN = '0;

    // 1: reset with both buttons held
    rst = 1'b1;
    bif.BTN_IN = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outs", 32'({bif.LEVEL, bif.PRESS, bif.RELEASE, bif.TOGGLE}), 32'h0);
    end
    t = cyc;
    rst = 1'b0;
    exp_q.push_back(mk_ev(t + 6, 0, KIND_PRESS));
    exp_q.push_back(mk_ev(t + 6, 1, KIND_PRESS));
    step(5);
    check("held_press_early", 32'(bif.PRESS), 32'h0);
    step();
    check("held_press", 32'(bif.PRESS), 32'h3);
    check("held_level", 32'(bif.LEVEL), 32'h3);
    step();
    check("held_press_clear", 32'(bif.PRESS), 32'h0);
    check("held_toggle", 32'(bif.TOGGLE), 32'h3);
    bif.BTN_IN = 2'b00;
    t = cyc;
    exp_q.push_back(mk_ev(t + 6, 0, KIND_RELEASE));
    exp_q.push_back(mk_ev(t + 6, 1, KIND_RELEASE));
    step(8);
    check("drain1", 32'(exp_q.size()), 32'h0);

    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("toggle_after_reset", 32'(bif.TOGGLE), 32'h0);

    // 2: clean press on ch0
    bif.BTN_IN[0] = 1'b1;
    t = cyc;
    exp_q.push_back(mk_ev(t + 6, 0, KIND_PRESS));
    step(5);
    check("clean_level_early", 32'(bif.LEVEL[0]), 32'h0);
    step();
    check("clean_level", 32'(bif.LEVEL[0]), 32'h1);
    check("clean_press", 32'(bif.PRESS[0]), 32'h1);
    check("clean_toggle", 32'(bif.TOGGLE[0]), 32'h1);
    step();
    check("clean_press_clear", 32'(bif.PRESS[0]), 32'h0);
    check("clean_toggle_hold", 32'(bif.TOGGLE[0]), 32'h1);
    step(3);
    bif.BTN_IN[0] = 1'b0;
    t = cyc;
    exp_q.push_back(mk_ev(t + 6, 0, KIND_RELEASE));
    step(8);
    check("drain2", 32'(exp_q.size()), 32'h0);
    check("release_toggle_hold", 32'(bif.TOGGLE[0]), 32'h1);

    // 3: 3-cycle glitch is rejected
    bif.BTN_IN[0] = 1'b1;
    step(3);
    bif.BTN_IN[0] = 1'b0;
    step(10);
    check("glitch_level", 32'(bif.LEVEL[0]), 32'h0);
    check("glitch_toggle", 32'(bif.TOGGLE[0]), 32'h1);
    check("drain3", 32'(exp_q.size()), 32'h0);

    // 4: bouncing press yields one pulse after the last rising edge
    t = 0;
    for (int i = 0; i < 9; i++) begin
      if (bounce_pat[i] && !bif.BTN_IN[0]) t = cyc;
      bif.BTN_IN[0] = bounce_pat[i];
      step();
    end
    exp_q.push_back(mk_ev(t + 6, 0, KIND_PRESS));
    step(8);
    check("drain4", 32'(exp_q.size()), 32'h0);
    check("bounce_level", 32'(bif.LEVEL[0]), 32'h1);
    check("bounce_toggle", 32'(bif.TOGGLE[0]), 32'h0);
    bif.BTN_IN[0] = 1'b0;
    t = cyc;
    exp_q.push_back(mk_ev(t + 6, 0, KIND_RELEASE));
    step(8);
    check("drain4r", 32'(exp_q.size()), 32'h0);

    // 5: two press/release cycles on ch1, ch0 quiet
    for (int rep = 0; rep < 2; rep++) begin
      bif.BTN_IN[1] = 1'b1;
      t = cyc;
      exp_q.push_back(mk_ev(t + 6, 1, KIND_PRESS));
      step(8);
      check("ch1_toggle", 32'(bif.TOGGLE[1]), (rep == 0) ? 32'h1 : 32'h0);
      check("ch1_level_hi", 32'(bif.LEVEL[1]), 32'h1);
      bif.BTN_IN[1] = 1'b0;
      t = cyc;
      exp_q.push_back(mk_ev(t + 6, 1, KIND_RELEASE));
      step(8);
      check("ch1_level_lo", 32'(bif.LEVEL[1]), 32'h0);
      check("ch0_quiet", 32'({bif.LEVEL[0], bif.TOGGLE[0]}), 32'h0);
    end
    check("drain5", 32'(exp_q.size()), 32'h0);

    // 6: reset in the middle of a debounce restarts it
    bif.BTN_IN[0] = 1'b1;
    step(3);
    rst = 1'b1;
    step();
    t = cyc;
    rst = 1'b0;
    exp_q.push_back(mk_ev(t + 6, 0, KIND_PRESS));
    step(5);
    check("midreset_early", 32'(bif.PRESS[0]), 32'h0);
    step();
    check("midreset_press", 32'(bif.PRESS[0]), 32'h1);
    step(3);
    check("midreset_toggle", 32'(bif.TOGGLE[0]), 32'h1);
    check("drain6", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
